// File: rtl/sdi_pkg.sv
// Shared constants and helpers for the HD-SDI line formatter: 1080p30 raster
// defaults, TRS and blanking code words, and the protected XYZ word builder.
package sdi_pkg;

    localparam int DEF_TOTAL_WORDS  = 4400;
    localparam int DEF_SAV_WORD     = 552;
    localparam int DEF_TOTAL_LINES  = 1125;
    localparam int DEF_ACTIVE_FIRST = 41;
    localparam int DEF_ACTIVE_LINES = 1080;

    localparam int DATA_W      = 10;
    localparam int WORD_CNT_W  = 13;
    localparam int LINE_CNT_W  = 11;
    localparam int FRAME_CNT_W = 16;

    localparam logic [DATA_W-1:0] TRS_ONES  = 10'h3FF;
    localparam logic [DATA_W-1:0] TRS_ZEROS = 10'h000;
    localparam logic [DATA_W-1:0] BLANK_C   = 10'h200;
    localparam logic [DATA_W-1:0] BLANK_Y   = 10'h040;

    // Protection bits let the receiver correct single-bit errors in F/V/H.
    function automatic logic [DATA_W-1:0] xyz(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
    endfunction

endpackage

// File: rtl/sdi_timing_counter.sv
// Word/line/frame raster counters plus region decode. The counters address the
// word that the formatter loads into its output register at the next edge.
module sdi_timing_counter
    import sdi_pkg::*;
#(
    parameter int TOTAL_WORDS  = DEF_TOTAL_WORDS,
    parameter int SAV_WORD     = DEF_SAV_WORD,
    parameter int TOTAL_LINES  = DEF_TOTAL_LINES,
    parameter int ACTIVE_FIRST = DEF_ACTIVE_FIRST,
    parameter int ACTIVE_LINES = DEF_ACTIVE_LINES
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    output logic [WORD_CNT_W-1:0]  o_word,
    output logic [LINE_CNT_W-1:0]  o_line,
    output logic [FRAME_CNT_W-1:0] o_frame,
    output logic                   o_in_trs,
    output logic                   o_is_eav,
    output logic [2:0]             o_trs_idx,
    output logic                   o_active_line,
    output logic                   o_active_word,
    output logic                   o_fetch_next
);

    localparam logic [WORD_CNT_W-1:0] LAST_WORD  = WORD_CNT_W'(TOTAL_WORDS - 1);
    localparam logic [WORD_CNT_W-1:0] TRS_LEN    = WORD_CNT_W'(8);
    localparam logic [WORD_CNT_W-1:0] SAV_START  = WORD_CNT_W'(SAV_WORD);
    localparam logic [WORD_CNT_W-1:0] ACT_START  = WORD_CNT_W'(SAV_WORD + 8);
    localparam logic [WORD_CNT_W-1:0] PRE_ACT    = WORD_CNT_W'(SAV_WORD + 7);
    localparam logic [2:0]            SAV_LO     = 3'(SAV_WORD % 8);
    localparam logic [LINE_CNT_W-1:0] LAST_LINE  = LINE_CNT_W'(TOTAL_LINES - 1);
    localparam logic [LINE_CNT_W-1:0] ACT_FIRST  = LINE_CNT_W'(ACTIVE_FIRST);
    localparam logic [LINE_CNT_W-1:0] ACT_END    = LINE_CNT_W'(ACTIVE_FIRST + ACTIVE_LINES);

    logic [WORD_CNT_W-1:0]  r_word;
    logic [LINE_CNT_W-1:0]  r_line;
    logic [FRAME_CNT_W-1:0] r_frame;
    logic                   w_eav;
    logic                   w_sav;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word  <= '0;
            r_line  <= '0;
            r_frame <= '0;
        end else if (r_word == LAST_WORD) begin
            r_word <= '0;
            if (r_line == LAST_LINE) begin
                r_line  <= '0;
                r_frame <= r_frame + 1'b1;
            end else begin
                r_line <= r_line + 1'b1;
            end
        end else begin
            r_word <= r_word + 1'b1;
        end
    end

    assign w_eav = (r_word < TRS_LEN);
    assign w_sav = (r_word >= SAV_START) && (r_word < ACT_START);

    assign o_word        = r_word;
    assign o_line        = r_line;
    assign o_frame       = r_frame;
    assign o_in_trs      = w_eav | w_sav;
    assign o_is_eav      = w_eav;
    assign o_trs_idx     = w_eav ? r_word[2:0] : (r_word[2:0] - SAV_LO);
    assign o_active_line = (r_line >= ACT_FIRST) && (r_line < ACT_END);
    assign o_active_word = (r_word >= ACT_START);
    // Next word is an active C word: the last odd word before it raises ready.
    assign o_fetch_next  = o_active_line && r_word[0] && (r_word >= PRE_ACT) && (r_word != LAST_WORD);

endmodule

// File: rtl/sdi_line_formatter.sv
// HD-SDI interleaved C/Y word stream builder: TRS insertion, black blanking and
// a registered-lookahead pixel-pair handshake that never stalls raster timing.
module sdi_line_formatter
    import sdi_pkg::*;
#(
    parameter int TOTAL_WORDS  = DEF_TOTAL_WORDS,
    parameter int SAV_WORD     = DEF_SAV_WORD,
    parameter int TOTAL_LINES  = DEF_TOTAL_LINES,
    parameter int ACTIVE_FIRST = DEF_ACTIVE_FIRST,
    parameter int ACTIVE_LINES = DEF_ACTIVE_LINES
) (
    input  logic                   iCLK,
    input  logic                   iRESET,
    input  logic                   iPIX_VALID,
    input  logic [DATA_W-1:0]      iPIX_C,
    input  logic [DATA_W-1:0]      iPIX_Y,
    output logic                   oPIX_READY,
    input  logic                   iCLR_UNDERRUN,
    output logic [DATA_W-1:0]      oDATA,
    output logic                   oSOF,
    output logic [LINE_CNT_W-1:0]  oLINE,
    output logic [FRAME_CNT_W-1:0] oFRAME,
    output logic                   oUNDERRUN
);

    logic [WORD_CNT_W-1:0]  w_word;
    logic [LINE_CNT_W-1:0]  w_line;
    logic [FRAME_CNT_W-1:0] w_frame;
    logic                   w_in_trs;
    logic                   w_is_eav;
    logic [2:0]             w_trs_idx;
    logic                   w_active_line;
    logic                   w_active_word;
    logic                   w_fetch_next;
    logic                   w_active_c;
    logic                   w_xfer;
    logic [DATA_W-1:0]      w_trs_word;

    logic [DATA_W-1:0]      r_data;
    logic [DATA_W-1:0]      r_y;
    logic                   r_sof;
    logic [LINE_CNT_W-1:0]  r_line;
    logic [FRAME_CNT_W-1:0] r_frame;
    logic                   r_ready;
    logic                   r_underrun;

    sdi_timing_counter #(
        .TOTAL_WORDS  (TOTAL_WORDS),
        .SAV_WORD     (SAV_WORD),
        .TOTAL_LINES  (TOTAL_LINES),
        .ACTIVE_FIRST (ACTIVE_FIRST),
        .ACTIVE_LINES (ACTIVE_LINES)
    ) u_timing (
        .i_clk         (iCLK),
        .i_rst         (iRESET),
        .o_word        (w_word),
        .o_line        (w_line),
        .o_frame       (w_frame),
        .o_in_trs      (w_in_trs),
        .o_is_eav      (w_is_eav),
        .o_trs_idx     (w_trs_idx),
        .o_active_line (w_active_line),
        .o_active_word (w_active_word),
        .o_fetch_next  (w_fetch_next)
    );

    assign w_active_c = w_active_line & w_active_word & ~w_word[0];
    assign w_xfer     = r_ready & iPIX_VALID;

    always_comb begin
        w_trs_word = TRS_ZEROS;
        case (w_trs_idx)
            3'd0, 3'd1: w_trs_word = TRS_ONES;
            3'd6, 3'd7: w_trs_word = xyz(1'b0, ~w_active_line, w_is_eav);
            default:    w_trs_word = TRS_ZEROS;
        endcase
    end

    // Output stage: oDATA and its side-band flags leave on the same edge.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_data     <= BLANK_C;
            r_sof      <= 1'b0;
            r_line     <= '0;
            r_frame    <= '0;
            r_ready    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_sof      <= (w_word == '0) && (w_line == '0);
            r_line     <= w_line;
            r_frame    <= w_frame;
            r_ready    <= w_fetch_next;
            r_underrun <= (w_active_c & ~w_xfer) | (r_underrun & ~iCLR_UNDERRUN);
            if (w_in_trs)
                r_data <= w_trs_word;
            else if (w_active_c)
                r_data <= w_xfer ? iPIX_C : BLANK_C;
            else if (w_active_line && w_active_word)
                r_data <= r_y;
            else
                r_data <= w_word[0] ? BLANK_Y : BLANK_C;
        end
    end

    always_ff @(posedge iCLK) begin
        if (w_active_c)
            r_y <= w_xfer ? iPIX_Y : BLANK_Y;
    end

    assign oDATA      = r_data;
    assign oSOF       = r_sof;
    assign oLINE      = r_line;
    assign oFRAME     = r_frame;
    assign oPIX_READY = r_ready;
    assign oUNDERRUN  = r_underrun;

endmodule

// File: tb/tb_sdi_line_formatter.sv
// Randomized self-checking bench for sdi_line_formatter on a scaled-down raster.
module tb_sdi_line_formatter;

    localparam int TW    = 64;
    localparam int SAV   = 16;
    localparam int TL    = 12;
    localparam int AF    = 3;
    localparam int AL    = 6;
    localparam int PAIRS = (TW - SAV - 8) / 2;

    logic        iCLK = 1'b0;
    logic        iRESET = 1'b1;
    logic        iPIX_VALID = 1'b0;
    logic [9:0]  iPIX_C = 10'd0;
    logic [9:0]  iPIX_Y = 10'd0;
    logic        iCLR_UNDERRUN = 1'b0;
    logic        oPIX_READY;
    logic [9:0]  oDATA;
    logic        oSOF;
    logic [10:0] oLINE;
    logic [15:0] oFRAME;
    logic        oUNDERRUN;

    always #5 iCLK = ~iCLK;

    sdi_line_formatter #(
        .TOTAL_WORDS  (TW),
        .SAV_WORD     (SAV),
        .TOTAL_LINES  (TL),
        .ACTIVE_FIRST (AF),
        .ACTIVE_LINES (AL)
    ) dut (
        .iCLK          (iCLK),
        .iRESET        (iRESET),
        .iPIX_VALID    (iPIX_VALID),
        .iPIX_C        (iPIX_C),
        .iPIX_Y        (iPIX_Y),
        .oPIX_READY    (oPIX_READY),
        .iCLR_UNDERRUN (iCLR_UNDERRUN),
        .oDATA         (oDATA),
        .oSOF          (oSOF),
        .oLINE         (oLINE),
        .oFRAME        (oFRAME),
        .oUNDERRUN     (oUNDERRUN)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: raster position of the word on oDATA and of the next one.
    int npw = 0, npl = 0, npf = 0;
    int mw = -1, ml = -1;
    int nxfer = 0;
    logic [9:0]  e_data = 10'h200;
    logic [9:0]  m_y = 10'h040;
    logic [9:0]  pat = 10'd0;
    logic [9:0]  last_c = 10'd0;
    logic [9:0]  last_y = 10'd0;
    logic        e_sof = 1'b0, e_rdy = 1'b0, e_und = 1'b0;
    logic [10:0] e_line = 11'd0;
    logic [15:0] e_frame = 16'd0;
    bit          rand_gaps = 0, gap_req = 0, gap_now = 0;

    function automatic bit act_line(int l);
        return (l >= AF) && (l < AF + AL);
    endfunction

    function automatic bit act_c(int w, int l);
        return act_line(l) && (w >= SAV + 8) && (w % 2 == 0);
    endfunction

    function automatic logic [9:0] fixed_word(int w, int l);
        int  o;
        bit  eav;
        eav = (w < 8);
        o   = eav ? w : w - SAV;
        if (eav || (w >= SAV && w < SAV + 8)) begin
            if (o < 2) return 10'h3FF;
            if (o < 6) return 10'h000;
            if (act_line(l)) return eav ? 10'h274 : 10'h200;
            return eav ? 10'h2D8 : 10'h2AC;
        end
        return (w % 2 == 0) ? 10'h200 : 10'h040;
    endfunction

    task automatic tick();
        bit x, clr, rst, ac;
        logic [9:0] c, y;
        x   = (iPIX_VALID === 1'b1) && (oPIX_READY === 1'b1);
        clr = iCLR_UNDERRUN;
        rst = iRESET;
        c   = iPIX_C;
        y   = iPIX_Y;
        @(posedge iCLK);
        #1;
        gap_now = 0;
        if (rst) begin
            npw = 0; npl = 0; npf = 0; mw = -1; ml = -1;
            e_data = 10'h200; e_sof = 0; e_line = 0; e_frame = 0; e_und = 0; e_rdy = 0;
        end else begin
            mw = npw; ml = npl;
            ac = act_c(mw, ml);
            e_sof   = (mw == 0) && (ml == 0);
            e_line  = 11'(ml);
            e_frame = 16'(npf);
            if (x) begin
                nxfer++; pat = pat + 10'd2; last_c = c; last_y = y;
            end
            if (ac) begin
                e_data  = x ? c : 10'h200;
                m_y     = x ? y : 10'h040;
                gap_now = !x;
            end else if (act_line(ml) && mw >= SAV + 8) begin
                e_data = m_y;
            end else begin
                e_data = fixed_word(mw, ml);
            end
            e_und = (ac && !x) ? 1'b1 : (clr ? 1'b0 : e_und);
            npw++;
            if (npw == TW) begin
                npw = 0; npl++;
                if (npl == TL) begin npl = 0; npf = (npf + 1) % 65536; end
            end
            e_rdy = act_c(npw, npl);
        end
        if (oPIX_READY === 1'b1 && gap_req) begin
            iPIX_VALID = 1'b0; gap_req = 0;
            iPIX_C = 10'($urandom); iPIX_Y = 10'($urandom);
        end else if (oPIX_READY === 1'b1) begin
            iPIX_VALID = 1'b1; iPIX_C = pat; iPIX_Y = pat + 10'd1;
        end else begin
            iPIX_VALID = rand_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            iPIX_C = pat; iPIX_Y = pat + 10'd1;
        end
    endtask

    task automatic test_reset();
        logic [9:0] seq [8];
        seq = '{10'h3FF, 10'h3FF, 10'h000, 10'h000, 10'h000, 10'h000, 10'h2D8, 10'h2D8};
        iRESET = 1'b1;
        tick(); tick();
        checks += 6;
        if (oDATA !== 10'h200) begin failures++; $display("FAIL reset_data got=%h exp=200", oDATA); end
        if (oPIX_READY !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", oPIX_READY); end
        if (oSOF !== 1'b0) begin failures++; $display("FAIL reset_sof got=%b exp=0", oSOF); end
        if (oUNDERRUN !== 1'b0) begin failures++; $display("FAIL reset_und got=%b exp=0", oUNDERRUN); end
        if (oLINE !== 11'd0) begin failures++; $display("FAIL reset_line got=%0d exp=0", oLINE); end
        if (oFRAME !== 16'd0) begin failures++; $display("FAIL reset_frame got=%0d exp=0", oFRAME); end
        iRESET = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks += 3;
            if (oDATA !== seq[i]) begin failures++; $display("FAIL release_word%0d got=%h exp=%h", i, oDATA, seq[i]); end
            if (oSOF !== (i == 0)) begin failures++; $display("FAIL release_sof%0d got=%b exp=%b", i, oSOF, i == 0); end
            if (oLINE !== 11'd0) begin failures++; $display("FAIL release_line%0d got=%0d exp=0", i, oLINE); end
        end
    endtask

    task automatic test_active_line();
        int x0;
        for (int i = 0; i < TW * TL && !(ml == AF && mw == 0); i++) tick();
        checks++;
        if (!(ml == AF && mw == 0)) begin failures++; $display("FAIL active_line_wait got=%0d exp=%0d", ml, AF); return; end
        x0 = nxfer;
        for (int i = 1; i < TW; i++) begin
            tick();
            checks += 2;
            if (oDATA !== e_data) begin failures++; $display("FAIL active_word%0d got=%h exp=%h", mw, oDATA, e_data); end
            if (oPIX_READY !== e_rdy) begin failures++; $display("FAIL active_ready%0d got=%b exp=%b", mw, oPIX_READY, e_rdy); end
            if (mw == 6) begin
                checks++;
                if (oDATA !== 10'h274) begin failures++; $display("FAIL active_eav got=%h exp=274", oDATA); end
            end
            if (mw == SAV + 6) begin
                checks++;
                if (oDATA !== 10'h200) begin failures++; $display("FAIL active_sav got=%h exp=200", oDATA); end
            end
            if (mw == SAV + 8) begin
                checks++;
                if (oDATA !== last_c) begin failures++; $display("FAIL first_c got=%h exp=%h", oDATA, last_c); end
            end
            if (mw == SAV + 9) begin
                checks++;
                if (oDATA !== last_y) begin failures++; $display("FAIL first_y got=%h exp=%h", oDATA, last_y); end
            end
        end
        checks++;
        if (nxfer - x0 != PAIRS) begin failures++; $display("FAIL line_xfers got=%0d exp=%0d", nxfer - x0, PAIRS); end
    endtask

    task automatic test_underrun();
        rand_gaps = 0;
        for (int i = 0; i < TW * TL && !(ml == AF + 2 && mw == SAV + 20); i++) tick();
        gap_req = 1;
        for (int i = 0; i < TW * TL && !gap_now; i++) tick();
        checks += 2;
        if (!gap_now) begin failures++; $display("FAIL gap_wait got=0 exp=1"); return; end
        if (oDATA !== 10'h200) begin failures++; $display("FAIL gap_c got=%h exp=200", oDATA); end
        tick();
        checks += 2;
        if (oDATA !== 10'h040) begin failures++; $display("FAIL gap_y got=%h exp=040", oDATA); end
        if (oUNDERRUN !== 1'b1) begin failures++; $display("FAIL und_set got=%b exp=1", oUNDERRUN); end
        tick();
        checks += 2;
        if (oDATA !== last_c) begin failures++; $display("FAIL after_gap_c got=%h exp=%h", oDATA, last_c); end
        if (oDATA !== e_data) begin failures++; $display("FAIL after_gap_model got=%h exp=%h", oDATA, e_data); end
        iCLR_UNDERRUN = 1'b1;
        tick();
        iCLR_UNDERRUN = 1'b0;
        checks++;
        if (oUNDERRUN !== 1'b0) begin failures++; $display("FAIL und_clear got=%b exp=0", oUNDERRUN); end
        iCLR_UNDERRUN = 1'b1;
        gap_req = 1;
        for (int i = 0; i < TW * TL && !gap_now; i++) tick();
        checks++;
        if (oUNDERRUN !== 1'b1) begin failures++; $display("FAIL set_wins got=%b exp=1", oUNDERRUN); end
        tick();
        checks++;
        if (oUNDERRUN !== 1'b0) begin failures++; $display("FAIL clr_after_set got=%b exp=0", oUNDERRUN); end
        iCLR_UNDERRUN = 1'b0;
    endtask

    task automatic test_full_frame();
        int nsof = 0, cnt = 0, x0 = 0;
        rand_gaps = 1;
        for (int i = 0; i < 2 * TW * TL + 16 && nsof < 2; i++) begin
            tick();
            cnt++;
            checks += 6;
            if (oDATA !== e_data) begin failures++; $display("FAIL frame_data l%0d w%0d got=%h exp=%h", ml, mw, oDATA, e_data); end
            if (oPIX_READY !== e_rdy) begin failures++; $display("FAIL frame_ready l%0d w%0d got=%b exp=%b", ml, mw, oPIX_READY, e_rdy); end
            if (oUNDERRUN !== e_und) begin failures++; $display("FAIL frame_und l%0d w%0d got=%b exp=%b", ml, mw, oUNDERRUN, e_und); end
            if (oSOF !== e_sof) begin failures++; $display("FAIL frame_sof l%0d w%0d got=%b exp=%b", ml, mw, oSOF, e_sof); end
            if (oLINE !== e_line) begin failures++; $display("FAIL frame_line got=%0d exp=%0d", oLINE, e_line); end
            if (oFRAME !== e_frame) begin failures++; $display("FAIL frame_count got=%0d exp=%0d", oFRAME, e_frame); end
            if (ml == TL - 1 && mw == 6) begin
                checks++;
                if (oDATA !== 10'h2D8) begin failures++; $display("FAIL last_eav got=%h exp=2D8", oDATA); end
            end
            if (ml == TL - 1 && mw == SAV + 6) begin
                checks++;
                if (oDATA !== 10'h2AC) begin failures++; $display("FAIL last_sav got=%h exp=2AC", oDATA); end
            end
            if (oSOF === 1'b1) begin
                nsof++;
                checks += 2;
                if (oDATA !== 10'h3FF) begin failures++; $display("FAIL sof_word got=%h exp=3FF", oDATA); end
                if (oFRAME !== 16'(nsof)) begin failures++; $display("FAIL sof_frame got=%0d exp=%0d", oFRAME, nsof); end
                if (nsof == 2) begin
                    checks += 2;
                    if (cnt != TW * TL) begin failures++; $display("FAIL sof_spacing got=%0d exp=%0d", cnt, TW * TL); end
                    if (nxfer - x0 != AL * PAIRS) begin failures++; $display("FAIL frame_xfers got=%0d exp=%0d", nxfer - x0, AL * PAIRS); end
                end
                cnt = 0;
                x0 = nxfer;
            end
        end
        checks += 2;
        if (nsof < 2) begin failures++; $display("FAIL sof_wait got=%0d exp=2", nsof); end
        if (oUNDERRUN !== 1'b0) begin failures++; $display("FAIL stream_und got=%b exp=0", oUNDERRUN); end
        rand_gaps = 0;
    endtask

    task automatic test_reset_midline();
        logic [9:0] seq [8];
        seq = '{10'h3FF, 10'h3FF, 10'h000, 10'h000, 10'h000, 10'h000, 10'h2D8, 10'h2D8};
        for (int i = 0; i < TW * TL && !(ml == 5 && mw == 30); i++) tick();
        checks++;
        if (!(ml == 5 && mw == 30)) begin failures++; $display("FAIL midline_wait got=%0d exp=5", ml); end
        iRESET = 1'b1;
        tick();
        checks += 6;
        if (oDATA !== 10'h200) begin failures++; $display("FAIL mid_rst_data got=%h exp=200", oDATA); end
        if (oPIX_READY !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0", oPIX_READY); end
        if (oSOF !== 1'b0) begin failures++; $display("FAIL mid_rst_sof got=%b exp=0", oSOF); end
        if (oUNDERRUN !== 1'b0) begin failures++; $display("FAIL mid_rst_und got=%b exp=0", oUNDERRUN); end
        if (oLINE !== 11'd0) begin failures++; $display("FAIL mid_rst_line got=%0d exp=0", oLINE); end
        if (oFRAME !== 16'd0) begin failures++; $display("FAIL mid_rst_frame got=%0d exp=0", oFRAME); end
        iRESET = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks += 4;
            if (oDATA !== seq[i]) begin failures++; $display("FAIL restart_word%0d got=%h exp=%h", i, oDATA, seq[i]); end
            if (oSOF !== (i == 0)) begin failures++; $display("FAIL restart_sof%0d got=%b exp=%b", i, oSOF, i == 0); end
            if (oLINE !== 11'd0) begin failures++; $display("FAIL restart_line%0d got=%0d exp=0", i, oLINE); end
            if (oFRAME !== 16'd0) begin failures++; $display("FAIL restart_frame%0d got=%0d exp=0", i, oFRAME); end
        end
    endtask

    initial begin
        test_reset();
        test_active_line();
        test_underrun();
        test_full_frame();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdi_line_formatter.md
# sdi_line_formatter

Builds the 10-bit interleaved HD-SDI (SMPTE 292, 1080p30) word stream that feeds the external serializer's parallel port. It owns the line/word/frame timing, inserts EAV/SAV timing reference sequences with correctly protected XYZ words, and fills horizontal and vertical blanking with black. It pulls active-picture pixel pairs from an upstream pattern generator or frame-buffer reader over a valid/ready handshake. The serializer runs with IO processing enabled and inserts LN/CRC itself.

## Interface
- TOTAL_WORDS, 4400: words per line, C/Y interleaved.
- SAV_WORD, 552: index of the first SAV word; active picture starts at SAV_WORD+8.
- TOTAL_LINES, 1125: lines per frame.
- ACTIVE_FIRST, 41: first active line, 0-based counter.
- ACTIVE_LINES, 1080: number of active lines.
- iCLK  in  1  word clock, 148.5 MHz. Top level drives it with inverted PCLK so oDATA is stable at the serializer's rising-edge sample.
- iRESET  in  1  reset, synchronous, active-high.
- iPIX_VALID  in  1  upstream pair available.
- iPIX_C  in  10  chroma sample of the pair (Cb or Cr, alternating per pair).
- iPIX_Y  in  10  luma sample of the pair.
- oPIX_READY  out  1  pair accepted at this edge if iPIX_VALID.
- iCLR_UNDERRUN  in  1  clears oUNDERRUN.
- oDATA  out  10  word to serializer.
- oSOF  out  1  one-cycle pulse coincident with word 0 of line 0 on oDATA.
- oLINE  out  11  0-based line index of the word currently on oDATA.
- oFRAME  out  16  frame count, wraps at 0xFFFF→0.
- oUNDERRUN  out  1  sticky flag: a pair was required while iPIX_VALID was low.

## Operation
- Counters: word w runs 0..TOTAL_WORDS-1, line l runs 0..TOTAL_LINES-1, frame f is 16-bit. w wraps and increments l; l wraps and increments f.
- Active line: ACTIVE_FIRST ≤ l < ACTIVE_FIRST+ACTIVE_LINES. V=0 on active lines, otherwise V=1. F=0 always (progressive).
- Word map per line:
  - w 0–1: 0x3FF.
  - w 2–5: 0x000.
  - w 6–7: XYZ with H=1 (EAV).
  - w 8..SAV_WORD-1: blanking.
  - SAV_WORD..+1: 0x3FF.
  - +2..+5: 0x000.
  - +6..+7: XYZ with H=0 (SAV).
  - SAV_WORD+8..TOTAL_WORDS-1: active region.
- XYZ: bit9=1, bit8=F, bit7=V, bit6=H, bit5=V^H, bit4=F^H, bit3=F^V, bit2=F^V^H, bits1:0=0.
  - Active-line EAV = 0x274, SAV = 0x200.
  - Blank-line EAV = 0x2D8, SAV = 0x2AC.
- Blanking: even w → 0x200 (C), odd w → 0x040 (Y). This applies to horizontal blanking and to the whole active region of blank lines.
- Active region on active lines, even w:
  - The pair is fetched; C is emitted on even w and Y on the following odd w.
  - 1920 pairs per line.
- Underrun: if an active pair is fetched with iPIX_VALID=0, emit C=0x200, Y=0x040 for that pair and set oUNDERRUN. Timing is never stalled.
- oUNDERRUN is cleared by iCLR_UNDERRUN or reset. A set in the same cycle as a clear wins.
- Blank lines never assert oPIX_READY; the upstream block sees no handshakes there.

## Timing
- Reset values:
  - oDATA=0x200, oPIX_READY=0, oSOF=0, oUNDERRUN=0, oLINE=0, oFRAME=0.
  - Counters point at w=0, l=0.
- Reset mid-line: the line is abandoned immediately. No partial TRS is completed.
- First edge after iRESET deasserts: oDATA=0x3FF (w0, l0) and oSOF=1.
- oDATA, oSOF, oLINE and oFRAME are registered and mutually aligned.
- oPIX_READY:
  - Registered (lookahead decode), high exactly during the cycle whose rising edge loads an active C word into oDATA.
  - Transfer = iPIX_VALID & oPIX_READY at that edge.
  - C appears on oDATA 1 cycle after the edge, Y appears 2 cycles after.
  - oPIX_READY is high every other cycle across the active region: 1920 pulses per active line.
- iPIX_C/iPIX_Y are sampled only on transfer edges; a pair is held internally until Y is emitted.
- oFRAME increments with oSOF, i.e. when word 0 of line 0 appears.

## Structure
- Package sdi_pkg holds:
  - 1080p30 default constants.
  - TRS word constants (0x3FF, 0x000).
  - Blanking constants (0x200, 0x040).
  - A function xyz(F,V,H) returning the protected 10-bit word.
- One sub-module, sdi_timing_counter: w/l/f counters plus region decode (in_trs, is_eav, active_line, active_word, fetch_next). The formatter muxes words and handles the handshake.

## Test plan
- Reset release, iPIX_VALID=1 constant → first 8 words 3FF,3FF,000,000,000,000,2D8,2D8. oSOF=1 on the first word only. oLINE=0.
- Run to l=41 → EAV XYZ 0x274, SAV XYZ 0x200. Exactly 1920 transfers on that line. First active oDATA = iPIX_C of the first pair, then iPIX_Y.
- Upstream incrementing pattern C=n, Y=n+1 with random valid gaps only on non-ready cycles → output matches the sequence with no underrun.
- iPIX_VALID=0 for one ready cycle on line 500 → that pair emits 0x200/0x040 and oUNDERRUN rises. The next pair is correct. Asserting iCLR_UNDERRUN clears the flag.
- Full frame → line l=1124 uses XYZ 0x2D8/0x2AC. The next word is 3FF with oSOF=1 and oFRAME=1. Total words between oSOF pulses = 4,950,000.
- Assert iRESET at w=2000 of line 100 → next cycle outputs match the reset values. After release, the sequence restarts at w0/l0.
